// File: rtl/sd_sector_pkg.sv
// Shared types and bit positions for the SD sector controller.
// No logic: enum, strobe bit indices and ZPU_IN2 field layout only.
package sd_sector_pkg;
    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    localparam int LBA_SEL_BIT  = 0;
    localparam int BLOCK_RD_BIT = 1;
    localparam int BLOCK_WR_BIT = 2;
    localparam int IO_WR_BIT    = 5;
    localparam int DATA_WR_BIT  = 6;
    localparam int DATA_RD_BIT  = 2;

    localparam int IN2_IO_DONE  = 0;
    localparam int IN2_MOUNTED  = 1;
    localparam int IN2_FILENO   = 2;
    localparam int IN2_FILETYPE = 5;
    localparam int IN2_READONLY = 7;
endpackage

// File: rtl/sd_sector_ctrl_strobe_edge.sv
// Edge detector on a DEPTH-stage delayed copy of a strobe; rise/fall are combinational.
// Latency: edge reported DEPTH-1 cycles after first sample; no backpressure.
module strobe_edge #(
    parameter int DEPTH = 1
) (
    input  logic CLK_VIDEO,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [DEPTH-1:0] dly;
    logic [DEPTH:0]   taps;

    assign taps = {dly, d};

    always_ff @(posedge CLK_VIDEO) begin
        if (reset) dly <= '0;
        else       dly <= taps[DEPTH-1:0];
    end

    assign rise =  taps[DEPTH-1] & ~taps[DEPTH];
    assign fall = ~taps[DEPTH-1] &  taps[DEPTH];
endmodule

// File: rtl/sd_sector_ctrl.sv
// ZPU <-> hps_io SD sector sequencer, sector-buffer arbiter and mount status tracker.
// Latency: block strobes act next cycle, data_wr 2 cycles after rise; no backpressure, HPS owns buffer outside IDLE.
module sd_sector_ctrl
    import sd_sector_pkg::*;
#(
    parameter int BUF_AW = 9,
    parameter int TMO_W  = 24
) (
    input  logic              CLK_VIDEO,
    input  logic              reset,
    input  logic [31:0]       zpu_out2,
    input  logic [31:0]       zpu_out3,
    input  logic [15:0]       zpu_wr,
    input  logic [15:0]       zpu_rd,
    output logic [7:0]        zpu_in2,
    output logic [31:0]       zpu_in3,
    output logic [BUF_AW-1:0] buf_addr,
    output logic              buf_wr,
    input  logic [7:0]        buf_q,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic              img_mounted,
    input  logic [63:0]       img_size,
    input  logic [7:0]        ioctl_index,
    output logic              err
);
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             io_done, mounted, readonly;
    logic [1:0]       filetype;
    logic [2:0]       fileno;
    logic [31:0]      filesize;

    logic lba_sel, io_wr;
    logic wr_rise, rd_fall, brd_rise, bwr_rise, ack_fall, mnt_rise;
    logic unused_wr_fall, unused_rd_rise, unused_brd_fall, unused_bwr_fall;
    logic unused_ack_rise, unused_mnt_fall;

    assign lba_sel = zpu_out2[LBA_SEL_BIT];
    assign io_wr   = zpu_wr[IO_WR_BIT];

    strobe_edge #(.DEPTH(2)) u_data_wr (.CLK_VIDEO(CLK_VIDEO), .reset(reset),
        .d(zpu_wr[DATA_WR_BIT]), .rise(wr_rise), .fall(unused_wr_fall));
    strobe_edge #(.DEPTH(1)) u_data_rd (.CLK_VIDEO(CLK_VIDEO), .reset(reset),
        .d(zpu_rd[DATA_RD_BIT]), .rise(unused_rd_rise), .fall(rd_fall));
    strobe_edge #(.DEPTH(1)) u_block_rd (.CLK_VIDEO(CLK_VIDEO), .reset(reset),
        .d(zpu_out2[BLOCK_RD_BIT]), .rise(brd_rise), .fall(unused_brd_fall));
    strobe_edge #(.DEPTH(1)) u_block_wr (.CLK_VIDEO(CLK_VIDEO), .reset(reset),
        .d(zpu_out2[BLOCK_WR_BIT]), .rise(bwr_rise), .fall(unused_bwr_fall));
    strobe_edge #(.DEPTH(1)) u_ack (.CLK_VIDEO(CLK_VIDEO), .reset(reset),
        .d(sd_ack), .rise(unused_ack_rise), .fall(ack_fall));
    strobe_edge #(.DEPTH(1)) u_mount (.CLK_VIDEO(CLK_VIDEO), .reset(reset),
        .d(img_mounted), .rise(mnt_rise), .fall(unused_mnt_fall));

    // ZPU-side buffer port: writes only while the HPS side is not using the buffer
    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            buf_wr   <= 1'b0;
            buf_addr <= '0;
            sd_lba   <= '0;
        end else begin
            buf_wr <= wr_rise && !lba_sel && (state == IDLE);
            if (wr_rise && lba_sel)
                sd_lba <= zpu_out3;
            if (io_wr)
                buf_addr <= '0;
            else if (buf_wr || rd_fall)
                buf_addr <= buf_addr + 1'b1;
        end
    end

    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            state   <= IDLE;
            tmo_cnt <= '0;
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            io_done <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (brd_rise) begin
                        sd_rd   <= 1'b1;
                        io_done <= 1'b0;
                        state   <= REQ;
                    end else if (bwr_rise) begin
                        sd_wr   <= 1'b1;
                        io_done <= 1'b0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (sd_ack) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= XFER;
                    end else if (tmo_cnt == TMO_LAST) begin
                        sd_rd   <= 1'b0;
                        sd_wr   <= 1'b0;
                        io_done <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (ack_fall) begin
                        io_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (io_wr)
                err <= 1'b0;
            else if ((state == IDLE && brd_rise && bwr_rise) ||
                     (state != IDLE && (brd_rise || bwr_rise)) ||
                     (state != IDLE && wr_rise && !lba_sel) ||
                     (state == REQ && !sd_ack && tmo_cnt == TMO_LAST))
                err <= 1'b1;
        end
    end

    // Mount tracking runs regardless of any transfer in flight
    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            fileno   <= '0;
            filetype <= '0;
            readonly <= 1'b0;
            filesize <= '0;
            mounted  <= |img_size[31:0];
        end else if (mnt_rise) begin
            fileno   <= '0;
            filetype <= ioctl_index[7:6];
            readonly <= 1'b1;
            filesize <= img_size[31:0];
            mounted  <= ~mounted;
        end
    end

    always_comb begin
        zpu_in2                     = '0;
        zpu_in2[IN2_IO_DONE]        = io_done;
        zpu_in2[IN2_MOUNTED]        = mounted;
        zpu_in2[IN2_FILENO +: 3]    = fileno;
        zpu_in2[IN2_FILETYPE +: 2]  = filetype;
        zpu_in2[IN2_READONLY]       = readonly;
    end

    assign zpu_in3 = lba_sel ? filesize : {24'b0, buf_q};

    logic unused_ok;
    assign unused_ok = &{1'b0, zpu_out2[31:3], zpu_wr[15:7], zpu_wr[4:0], zpu_rd[15:3],
                         zpu_rd[1:0], ioctl_index[5:0], img_size[63:32], unused_wr_fall,
                         unused_rd_rise, unused_brd_fall, unused_bwr_fall, unused_ack_rise,
                         unused_mnt_fall};
endmodule

// File: doc/sd_sector_ctrl.md
Name: sd_sector_ctrl

Overview:
Sequences 512-byte SD sector transfers between the ZPU control processor and hps_io, and arbitrates the shared sector dual-port buffer between them. It latches the LBA, decodes ZPU strobes, generates the sd_rd/sd_wr/sd_ack handshake, and tracks image mount/status. It drives the ZPU_IN2/ZPU_IN3 status words. It sits between atari5200top (ZPU ports) and hps_io/dpram in emu.

Parameters:
BUF_AW, 9, sector buffer address width (512 bytes).
TMO_W, 24, request-timeout counter width; timeout fires at 2^TMO_W-1 cycles in REQ.

Ports:
CLK_VIDEO  in  1  clock (equals clk_sys in this core).
reset  in  1  synchronous, active-high.
zpu_out2  in  32  bit0 lba_sel, bit1 block_rd, bit2 block_wr (levels).
zpu_out3  in  32  ZPU write data (LBA or byte in [7:0]).
zpu_wr  in  16  write strobes; [5] io_wr (pointer clear), [6] data_wr.
zpu_rd  in  16  read strobes; [2] data_rd.
zpu_in2  out  8  {readonly, filetype[1:0], fileno[2:0], mounted, io_done}.
zpu_in3  out  32  lba_sel ? filesize : {24'b0, buf_q}.
buf_addr  out  BUF_AW  ZPU-side buffer address.
buf_wr  out  1  ZPU-side buffer write enable.
buf_q  in  8  ZPU-side buffer read data.
sd_lba  out  32  sector number to hps_io.
sd_rd  out  1  sector read request.
sd_wr  out  1  sector write request.
sd_ack  in  1  hps_io acknowledge, high for the whole transfer.
img_mounted  in  1  mount strobe from hps_io.
img_size  in  64  image size in bytes.
ioctl_index  in  8  file index; [7:6] gives filetype.
err  out  1  sticky: timeout or request while busy; cleared by io_wr.

Behaviour:
- Reset values. The following outputs go to 0: state=IDLE, sd_rd, sd_wr, buf_wr, buf_addr, sd_lba, err, io_done, fileno, filetype, readonly, filesize. mounted <= |img_size[31:0]. All edge-detect history registers go to 0.
- data_wr:
  - Rising edge is detected on a two-stage delayed copy, so the action happens 2 cycles after the strobe rises.
  - lba_sel=1: sd_lba <= zpu_out3.
  - lba_sel=0 and state==IDLE: buf_wr pulses for 1 cycle, and buf_addr+1 on the following cycle.
  - lba_sel=0 and state!=IDLE: the write is dropped and err is set (buffer is owned by HPS).
- data_rd: on the falling edge (1-stage delay), buf_addr+1. zpu_in3 is combinational from buf_q, with 1-cycle RAM latency.
- io_wr high: buf_addr <= 0 and err <= 0. This has priority over any increment in the same cycle.
- buf_addr wraps from 511 to 0 with no flag.
- FSM:
  - IDLE: a rising edge of block_rd sets sd_rd=1 and io_done=0, go REQ. A rising edge of block_wr sets sd_wr=1 and io_done=0, go REQ. If both rise together, the read wins and the write is dropped with err=1.
  - REQ: if sd_ack=1, clear sd_rd and sd_wr, go XFER. If the timeout counter saturates, clear the requests, set io_done=1 and err=1, go IDLE. The counter restarts at every REQ entry.
  - XFER: on sd_ack falling (1 → 0), set io_done=1, go IDLE.
  - Block edges seen outside IDLE are ignored and set err=1.
- Mount: on the rising edge of img_mounted, set fileno<=0, filetype<=ioctl_index[7:6], readonly<=1, filesize<=img_size[31:0], and toggle mounted. This is independent of the FSM. A mount during XFER does not abort the transfer.
- Reset mid-transfer: the FSM returns to IDLE and requests drop within 1 cycle. A later sd_ack from hps_io is ignored while in IDLE.

Decomposition:
- Package sd_sector_pkg holds:
  - state enum {IDLE, REQ, XFER};
  - bit-index localparams for lba_sel, block_rd, block_wr, io_wr, data_wr, data_rd;
  - ZPU_IN2 field positions.
- One sub-module, strobe_edge (parameterised delay depth, rise/fall outputs), instanced per strobe.

Test Plan:
- LBA latch: lba_sel=1, data_wr pulse with zpu_out3=0x0000_1234 → sd_lba=0x1234 2 cycles after the edge; buf_wr stays 0.
- Sector read: block_rd rises → sd_rd=1 and io_done=0 next cycle. ack high for 600 cycles → sd_rd clears on the first ack cycle, and io_done=1 one cycle after ack falls.
- Buffer fill: io_wr, then 3 data_wr with bytes 0xA1, 0xA2, 0xA3 → buf_wr pulses at addresses 0, 1, 2, final buf_addr=3. Then 512 data_rd from address 0 → buf_addr wraps back to 0.
- Lockout: data_wr during XFER → no buf_wr and err=1. A following io_wr → err=0 and buf_addr=0.
- Timeout (TMO_W=4 in bench): block_wr with no ack → after 15 cycles sd_wr=0, io_done=1, err=1.
- Mount: img_size=0x2000, ioctl_index=0x40, img_mounted pulse → zpu_in2=0b1_01_000_1_x and zpu_in3=0x2000 with lba_sel=1. A reset afterwards keeps mounted=1.
